// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-requester front end for the shared 8-bit ALU (option: ALU_ARBITER_DIVZERO_CHK_EN)
module alu_arbiter #(
    parameter int DW = 8,
    parameter int FW = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          req0_valid_i,
    output logic          req0_ready_o,
    input  logic [FW-1:0] req0_fun_i,
    input  logic [DW-1:0] req0_a_i,
    input  logic [DW-1:0] req0_b_i,
    input  logic          req1_valid_i,
    output logic          req1_ready_o,
    input  logic [FW-1:0] req1_fun_i,
    input  logic [DW-1:0] req1_a_i,
    input  logic [DW-1:0] req1_b_i,
    output logic [DW-1:0] alu_a_o,
    output logic [DW-1:0] alu_b_o,
    output logic [FW-1:0] alu_fun_o,
    input  logic [DW-1:0] alu_out_i,
    input  logic [3:0]    alu_flags_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic          rsp_id_o,
    output logic [DW-1:0] rsp_data_o,
    output logic [3:0]    rsp_flags_o,
    output logic          rsp_err_o
);

    // Function code the ALU treats as "do nothing, output 0"; used as the idle value.
    localparam logic [FW-1:0] FUN_IDLE = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [FW-1:0] alu_fun_q, alu_fun_d;
    logic          rsp_id_q, rsp_id_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]    rsp_flags_q, rsp_flags_d;
    logic          grant;
    logic          any_req;

`ifdef ALU_ARBITER_DIVZERO_CHK_EN
    localparam logic [FW-1:0] FUN_DIV = FW'(3);
    logic rsp_err_q, rsp_err_d;
    logic div_zero;
    assign div_zero  = (alu_fun_q == FUN_DIV) && (alu_b_q == '0);
    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    // Round-robin pick: a lone requester wins outright, a tie goes to ptr.
    always_comb begin
        any_req = req0_valid_i | req1_valid_i;
        grant   = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = ptr_q;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end
        req0_ready_o = (state_q == IDLE) && any_req && (grant == 1'b0);
        req1_ready_o = (state_q == IDLE) && any_req && (grant == 1'b1);
    end

    // Next-state and register updates for accept, capture and response hand-off.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
`ifdef ALU_ARBITER_DIVZERO_CHK_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    rsp_id_d  = grant;
                    alu_fun_d = grant ? req1_fun_i : req0_fun_i;
                    alu_a_d   = grant ? req1_a_i   : req0_a_i;
                    alu_b_d   = grant ? req1_b_i   : req0_b_i;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
`ifdef ALU_ARBITER_DIVZERO_CHK_EN
                if (div_zero) begin
                    rsp_data_d  = '1;
                    rsp_flags_d = 4'b0000;
                    rsp_err_d   = 1'b1;
                end else begin
                    rsp_data_d  = alu_out_i;
                    rsp_flags_d = alu_flags_i;
                    rsp_err_d   = 1'b0;
                end
`else
                rsp_data_d  = alu_out_i;
                rsp_flags_d = alu_flags_i;
`endif
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    ptr_d   = ~rsp_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= FUN_IDLE;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

`ifdef ALU_ARBITER_DIVZERO_CHK_EN
    // Divide-by-zero error flag, captured alongside the result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end
`endif

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_flags_o = rsp_flags_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_fun_o   = alu_fun_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_fun, req1_fun;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_fun, alu_flags;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.DW(8), .FW(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_fun_i(req0_fun), .req0_a_i(req0_a), .req0_b_i(req0_b),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_fun_i(req1_fun), .req1_a_i(req1_a), .req1_b_i(req1_b),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_fun_o(alu_fun),
        .alu_out_i(alu_out), .alu_flags_i(alu_flags),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_data_o(rsp_data), .rsp_flags_o(rsp_flags), .rsp_err_o(rsp_err)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: ADD/SUB/DIV raise Arith, compare raises CMP (a>b ->2, a==b ->1, else 0).
    always_comb begin
        alu_out   = 8'h00;
        alu_flags = 4'b0000;
        case (alu_fun)
            4'b0000: begin alu_out = alu_a + alu_b; alu_flags = 4'b1000; end
            4'b0001: begin alu_out = alu_a - alu_b; alu_flags = 4'b1000; end
            4'b0011: begin alu_out = (alu_b == 8'h00) ? 8'h00 : alu_a / alu_b; alu_flags = 4'b1000; end
            4'b1011: begin
                alu_out   = (alu_a > alu_b) ? 8'd2 : ((alu_a == alu_b) ? 8'd1 : 8'd0);
                alu_flags = 4'b0100;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [7:0] data,
                             input logic [3:0] flags, input logic err);
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_id"},    rsp_id,    id);
        check({tag, "_data"},  rsp_data,  data);
        check({tag, "_flags"}, rsp_flags, flags);
        check({tag, "_err"},   rsp_err,   err);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_cleared", rsp_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_fun = 4'h0; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_fun = 4'h0; req1_a = 8'h00; req1_b = 8'h00;
        tick(); tick();
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_alu_fun",   alu_fun,   4'hF);
        check("rst_alu_a",     alu_a,     8'h00);
        check("rst_alu_b",     alu_b,     8'h00);
        check("rst_rsp_data",  rsp_data,  8'h00);
        check("rst_rsp_flags", rsp_flags, 4'h0);
        check("rst_rsp_err",   rsp_err,   1'b0);
        check("rst_ready0",    req0_ready, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single requester ADD 5+3
        req0_valid = 1'b1; req0_fun = 4'b0000; req0_a = 8'd5; req0_b = 8'd3;
        #1;
        check("single_ready0", req0_ready, 1'b1);
        check("single_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        check("exec_alu_a",   alu_a,     8'd5);
        check("exec_alu_b",   alu_b,     8'd3);
        check("exec_alu_fun", alu_fun,   4'b0000);
        check("exec_valid",   rsp_valid, 1'b0);
        tick();
        check_rsp("single", 1'b0, 8'd8, 4'b1000, 1'b0);
        take_rsp();

        // Fresh reset, then dual request: ptr=0 favours req0
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        req0_valid = 1'b1; req0_fun = 4'b0000; req0_a = 8'd5; req0_b = 8'd3;
        req1_valid = 1'b1; req1_fun = 4'b0001; req1_a = 8'd9; req1_b = 8'd4;
        #1;
        check("dual_ready0", req0_ready, 1'b1);
        check("dual_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        tick();
        check_rsp("dual_first", 1'b0, 8'd8, 4'b1000, 1'b0);

        // Back-pressure with both requesters pending
        req0_valid = 1'b1; req0_fun = 4'b1011; req0_a = 8'd9; req0_b = 8'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid",  rsp_valid,  1'b1);
            check("stall_data",   rsp_data,   8'd8);
            check("stall_id",     rsp_id,     1'b0);
            check("stall_ready0", req0_ready, 1'b0);
            check("stall_ready1", req1_ready, 1'b0);
        end
        take_rsp();
        check("rr_ready0", req0_ready, 1'b0);
        check("rr_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        tick();
        check_rsp("dual_second", 1'b1, 8'd5, 4'b1000, 1'b0);
        take_rsp();

        // Compare 9 vs 3 from req0, now favoured again
        check("cmp_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        tick();
        check_rsp("cmp", 1'b0, 8'd2, 4'b0100, 1'b0);
        take_rsp();

        // Divide by zero from req1
        req1_valid = 1'b1; req1_fun = 4'b0011; req1_a = 8'd7; req1_b = 8'd0;
        #1;
        check("div_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        tick();
`ifdef ALU_ARBITER_DIVZERO_CHK_EN
        check_rsp("div0", 1'b1, 8'hFF, 4'b0000, 1'b1);
`else
        check_rsp("div0", 1'b1, 8'h00, 4'b1000, 1'b0);
`endif
        take_rsp();

        // Leave ptr=1 so the post-reset grant proves ptr was cleared
        req0_valid = 1'b1; req0_fun = 4'b0000; req0_a = 8'd1; req0_b = 8'd1;
        tick();
        req0_valid = 1'b0;
        tick();
        check_rsp("pre_rst", 1'b0, 8'd2, 4'b1000, 1'b0);
        take_rsp();

        // Reset during EXEC of a req1 operation
        req1_valid = 1'b1; req1_fun = 4'b0001; req1_a = 8'd6; req1_b = 8'd1;
        tick();
        req1_valid = 1'b0;
        check("mid_alu_fun", alu_fun, 4'b0001);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",   rsp_valid, 1'b0);
        check("mid_rst_alu_fun", alu_fun,   4'hF);
        check("mid_rst_alu_a",   alu_a,     8'h00);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_rsp", rsp_valid, 1'b0);
        end
        req0_valid = 1'b1; req0_fun = 4'b0000; req0_a = 8'd2; req0_b = 8'd2;
        req1_valid = 1'b1; req1_fun = 4'b0001; req1_a = 8'd2; req1_b = 8'd1;
        #1;
        check("post_rst_ready0", req0_ready, 1'b1);
        check("post_rst_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        tick();
        check_rsp("post_rst", 1'b0, 8'd4, 4'b1000, 1'b0);
        req1_valid = 1'b0;
        take_rsp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
